// File: rtl/alu_pkg.sv
// Shared definitions for the logic-op initiator and the logic-op unit it drives.
//  - log_op_e     : 3-bit operation codes understood by the logic-op unit
//  - init_state_e : initiator FSM states
//  - DEF_WIDTH / DEF_OPW : default operand and op-select widths
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_OPW   = 3;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANDN   = 3'd6,   // A & ~B
        OP_PASS_A = 3'd7
    } log_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } init_state_e;

endpackage

// File: rtl/op_timeout_cnt.sv
// Start-to-finish watchdog for the logic-op initiator.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : zero the count (asserted when a request is accepted)
//  enable     : count this cycle (asserted while waiting for finish)
//  expire     : combinational; high in the enabled cycle whose count is TIMEOUT-1
// The count saturates at TIMEOUT and never wraps. With TIMEOUT=0 no counter
// is built and expire is tied low.
module op_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_cnt
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

            logic [CW-1:0] count_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (enable && (count_reg != SAT)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            // The count equals the number of cycles already spent waiting,
            // so TIMEOUT-1 marks the last permitted waiting cycle.
            assign expire = enable && (count_reg == LAST);
        end else begin : g_none
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/logic_op_initiator.sv
// Requester side of the start/finish logic-op handshake.
// Ports:
//  clk, rst_n                         : clock, asynchronous active-low reset
//  req_valid/req_ready, req_a/b/op    : request port (accepted only in IDLE)
//  A, B, log_op, start                : registered operands and a one-cycle start to the unit
//  finish, C                          : unit completion (pulse or level) and result
//  res_valid/res_ready, res_data/err  : result port; res_err marks a timeout (data forced 0)
//  busy                               : any state other than IDLE
//  stray_fin                          : sticky, finish seen in IDLE or DONE
module logic_op_initiator
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OPW     = DEF_OPW,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   log_op,
    output logic             start,
    input  logic             finish,
    input  logic [WIDTH-1:0] C,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy,
    output logic             stray_fin
);

    init_state_e      state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_data_reg;
    logic [OPW-1:0]   op_reg;
    logic             res_err_reg, stray_fin_reg;

    logic accept, capture, timeout_hit, expire;

    op_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state_reg == WAIT),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // A combinational unit may answer in the start cycle itself.
                if (finish) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // finish takes priority over a simultaneous timeout.
                if (finish) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (expire) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            res_data_reg  <= '0;
            res_err_reg   <= 1'b0;
            stray_fin_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg  <= req_a;
                b_reg  <= req_b;
                op_reg <= req_op;
            end
            if (capture) begin
                res_data_reg <= C;
                res_err_reg  <= 1'b0;
            end else if (timeout_hit) begin
                res_data_reg <= '0;
                res_err_reg  <= 1'b1;
            end
            if (finish && ((state_reg == IDLE) || (state_reg == DONE))) begin
                stray_fin_reg <= 1'b1;
            end
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign start     = (state_reg == ISSUE);
    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign A         = a_reg;
    assign B         = b_reg;
    assign log_op    = op_reg;
    assign res_data  = res_data_reg;
    assign res_err   = res_err_reg;
    assign stray_fin = stray_fin_reg;

endmodule

// File: tb/tb_logic_op_initiator.sv
// Self-checking bench for logic_op_initiator. The logic-op unit is emulated
// in the bench: either combinational (finish = start) or answering k cycles
// after start. Expected results and result timing come from a simple
// timing rule: result appears k+2 cycles after accept, or TIMEOUT+2 on timeout.
module tb_logic_op_initiator;
    import alu_pkg::*;

    localparam int W       = 32;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_a, req_b;
    logic [2:0]    req_op;
    logic [W-1:0]  A, B;
    logic [2:0]    log_op;
    logic          start, finish, res_valid, res_ready, res_err, busy, stray_fin;
    logic [W-1:0]  C, res_data;

    logic comb_mode;
    logic finish_drv;

    int checks = 0;
    int errors = 0;
    logic exp_stray = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_ANDN: return a & ~b;
            default: return a;
        endcase
    endfunction

    // Emulated unit: result valid only while finish is high, garbage otherwise.
    assign finish = comb_mode ? start : finish_drv;
    assign C      = finish ? ref_op(A, B, log_op) : ~ref_op(A, B, log_op);

    logic_op_initiator #(
        .WIDTH   (W),
        .OPW     (3),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .A         (A),
        .B         (B),
        .log_op    (log_op),
        .start     (start),
        .finish    (finish),
        .C         (C),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy),
        .stray_fin (stray_fin)
    );

    // k: 0 = combinational unit, 1..TIMEOUT = finish k cycles after start,
    // NEVER = no finish. bp: cycles of res_ready=0 after res_valid rises.
    task automatic run_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input int k, input int bp);
        int n;
        int exp_n;
        logic [W-1:0] exp_data;
        logic exp_err;
        exp_err  = (k > TIMEOUT);
        exp_n    = exp_err ? TIMEOUT + 2 : k + 2;
        exp_data = exp_err ? '0 : ref_op(a, b, op);
        comb_mode  = (k == 0);
        finish_drv = 1'b0;
        res_ready  = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Scramble the request bus: held operands must not follow it.
                req_valid = 1'b0;
                req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
            end
            finish_drv = (k >= 1) && (k <= TIMEOUT) && (n == 1 + k);
            checks++;
            if (start !== (n == 1)) begin
                errors++; $display("FAIL %s start@%0d: got %b want %b", name, n, start, (n == 1));
            end
            checks++;
            if ((A !== a) || (B !== b) || (log_op !== op)) begin
                errors++; $display("FAIL %s operands@%0d: got %h/%h/%0d want %h/%h/%0d",
                                   name, n, A, B, log_op, a, b, op);
            end
            checks++;
            if (res_valid !== (n >= exp_n)) begin
                errors++; $display("FAIL %s res_valid@%0d: got %b want %b", name, n, res_valid, (n >= exp_n));
            end
            checks++;
            if ((busy !== 1'b1) || (req_ready !== 1'b0)) begin
                errors++; $display("FAIL %s busy@%0d: got busy=%b req_ready=%b want 1/0", name, n, busy, req_ready);
            end
        end while ((res_valid !== 1'b1) && (n < 40));
        finish_drv = 1'b0;
        checks++;
        if (n != exp_n) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_n);
        end
        checks++;
        if ((res_data !== exp_data) || (res_err !== exp_err)) begin
            errors++; $display("FAIL %s result: got %h err=%b want %h err=%b", name, res_data, res_err, exp_data, exp_err);
        end
        for (int i = 0; i < bp; i++) begin
            // A competing request during DONE must be ignored.
            req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
            @(negedge clk);
            checks++;
            if ((res_valid !== 1'b1) || (res_data !== exp_data) || (res_err !== exp_err) ||
                (req_ready !== 1'b0) || (A !== a) || (B !== b) || (log_op !== op)) begin
                errors++; $display("FAIL %s backpressure@%0d: got v=%b d=%h e=%b rdy=%b A=%h want 1/%h/%b/0/%h",
                                   name, i, res_valid, res_data, res_err, req_ready, A, exp_data, exp_err, a);
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ((res_valid !== 1'b0) || (req_ready !== 1'b1) || (busy !== 1'b0) || (A !== a)) begin
            errors++; $display("FAIL %s release: got v=%b rdy=%b busy=%b A=%h want 0/1/0/%h",
                               name, res_valid, req_ready, busy, A, a);
        end
        checks++;
        if (stray_fin !== exp_stray) begin
            errors++; $display("FAIL %s stray_fin: got %b want %b", name, stray_fin, exp_stray);
        end
        $display("txn %s: a=%h b=%h op=%0d k=%0d bp=%0d -> data=%h err=%b latency=%0d",
                 name, a, b, op, k, bp, res_data, res_err, n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        res_ready = 1'b0; comb_mode = 1'b0; finish_drv = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ((A !== '0) || (B !== '0) || (log_op !== '0) || (res_data !== '0) || (start !== 1'b0) ||
            (res_valid !== 1'b0) || (res_err !== 1'b0) || (busy !== 1'b0) || (stray_fin !== 1'b0)) begin
            errors++; $display("FAIL reset_outputs: got A=%h B=%h op=%0d d=%h st=%b v=%b e=%b busy=%b sf=%b want all 0",
                               A, B, log_op, res_data, start, res_valid, res_err, busy, stray_fin);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        $display("txn reset: released");
    endtask

    task automatic test_comb_unit();
        run_txn("comb_and", 32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 0, 0);
        checks++;
        if (res_data !== 32'hF000_F000) begin
            errors++; $display("FAIL comb_and_const: got %h want f000f000", res_data);
        end
    endtask

    task automatic test_delayed_finish();
        run_txn("delay5_or", 32'h1, 32'h2, OP_OR, 5, 0);
        checks++;
        if (res_data !== 32'h3) begin
            errors++; $display("FAIL delay5_or_const: got %h want 3", res_data);
        end
    endtask

    task automatic test_timeout();
        run_txn("timeout", $urandom, $urandom, 3'($urandom), NEVER, 0);
        run_txn("fin_at_timeout", 32'hDEAD_BEEF, 32'h0F0F_0F0F, OP_XOR, TIMEOUT, 0);
        run_txn("fin_before_timeout", $urandom, $urandom, OP_NAND, TIMEOUT - 1, 0);
    endtask

    task automatic test_backpressure();
        run_txn("bp10", 32'h1234_5678, 32'h8765_4321, OP_XNOR, 3, 10);
        run_txn("bp_next", 32'hAAAA_5555, 32'h5A5A_5A5A, OP_ANDN, 1, 0);
        run_txn("bp_timeout", $urandom, $urandom, OP_NOR, NEVER, 4);
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            int r;
            int k;
            r = $urandom_range(0, 9);
            k = (r == 0) ? 0 : (r == 1) ? NEVER : $urandom_range(1, TIMEOUT);
            run_txn("random", $urandom, $urandom, 3'($urandom_range(0, 7)), k, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_wait();
        comb_mode = 1'b0; finish_drv = 1'b0;
        req_valid = 1'b1; req_a = 32'hCAFE_F00D; req_b = 32'h1357_9BDF; req_op = OP_OR;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ((busy !== 1'b1) || (start !== 1'b0) || (res_valid !== 1'b0)) begin
            errors++; $display("FAIL midwait_state: got busy=%b st=%b v=%b want 1/0/0", busy, start, res_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ((A !== '0) || (B !== '0) || (log_op !== '0) || (res_data !== '0) || (start !== 1'b0) ||
            (res_valid !== 1'b0) || (res_err !== 1'b0) || (busy !== 1'b0) || (req_ready !== 1'b1)) begin
            errors++; $display("FAIL midwait_async_reset: got A=%h B=%h op=%0d d=%h st=%b v=%b e=%b busy=%b rdy=%b",
                               A, B, log_op, res_data, start, res_valid, res_err, busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TIMEOUT + 6; i++) begin
            @(negedge clk);
            checks++;
            if ((res_valid !== 1'b0) || (busy !== 1'b0)) begin
                errors++; $display("FAIL midwait_after_release@%0d: got v=%b busy=%b want 0/0", i, res_valid, busy);
            end
        end
        $display("txn reset_mid_wait: abandoned");
    endtask

    task automatic test_stray_finish();
        comb_mode = 1'b0;
        finish_drv = 1'b1;
        @(negedge clk);
        finish_drv = 1'b0;
        exp_stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ((stray_fin !== 1'b1) || (res_valid !== 1'b0) || (busy !== 1'b0)) begin
                errors++; $display("FAIL stray_idle: got sf=%b v=%b busy=%b want 1/0/0", stray_fin, res_valid, busy);
            end
        end
        $display("txn stray_finish: idle pulse");
        run_txn("after_stray", 32'h0000_FFFF, 32'h00FF_00FF, OP_XOR, 2, 1);
    endtask

    initial begin
        test_reset();
        test_comb_unit();
        test_delayed_finish();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        test_stray_finish();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
